// File: rtl/mode_seq_pkg.sv
// Shared types and helpers for the front-panel mode sequencer.
package mode_seq_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } seq_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int next_idx(input int idx, input int num_ch);
    return (idx == num_ch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mode_tick_counter.sv
// Tick-strobed counter: counts strobes while enabled, flags and wraps at TERM-1.
module mode_tick_counter
  import mode_seq_pkg::*;
#(
  parameter int TERM = 1,
  localparam int CNT_W = (TERM > 1) ? clog2(TERM) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic term
);

  logic [CNT_W-1:0] count;

  assign term = en && tick && (count == CNT_W'(TERM - 1));

  // clear has priority so a simultaneous strobe restarts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr)        count <= '0;
    else if (en && tick) count <= term ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/mode_sequencer.sv
// Registered NUM_CH-way display-source selector with step/jump/auto-rotate,
// set-bus lock and post-change display blanking.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int                NUM_CH      = 5,
  parameter int                DATA_W      = 32,
  parameter int                SET_W       = 2,
  parameter logic [NUM_CH-1:0] SET_MASK    = NUM_CH'(5'b00101),
  parameter int                DWELL_TICKS = 3000,
  parameter int                BLANK_TICKS = 50,
  localparam int               IDX_W       = clog2(NUM_CH)
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iNext,
  input  logic                     iJump,
  input  logic [IDX_W-1:0]         iJump_Idx,
  input  logic                     iAuto_En,
  input  logic                     iTick,
  input  logic [NUM_CH*DATA_W-1:0] iCh_Data,
  input  logic [NUM_CH*SET_W-1:0]  iCh_Set,
  output logic [NUM_CH-1:0]        oMode,
  output logic [IDX_W-1:0]         oMode_Idx,
  output logic [SET_W-1:0]         oMode_Set,
  output logic [DATA_W-1:0]        oMode_Data,
  output logic                     oValid,
  output logic                     oChanged
);

  localparam int BLANK_TERM = (BLANK_TICKS > 0) ? BLANK_TICKS : 1;

  seq_state_t        state, state_next;
  logic [IDX_W-1:0]  idx, target;
  logic [NUM_CH-1:0] mode, mode_next;
  logic [DATA_W-1:0] data_arr [NUM_CH];
  logic [SET_W-1:0]  set_arr [NUM_CH];
  logic              lock, req, change, show_now;
  logic              auto_req, blank_done, dwell_clr;
  logic [DATA_W-1:0] data_p1;
  logic [SET_W-1:0]  set_p1;
  logic              valid_p1, changed_p1;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      data_arr[k] = iCh_Data[k*DATA_W +: DATA_W];
      set_arr[k]  = iCh_Set[k*SET_W +: SET_W];
    end
  end

  assign lock = SET_MASK[idx] && (|set_arr[idx]);

  // Request arbitration: valid jump, then step, then auto; a jump to the
  // current index is accepted (restarts dwell) but is not a change.
  always_comb begin
    req        = 1'b0;
    target     = idx;
    state_next = state;
    mode_next  = '0;
    if (!lock) begin
      if (iJump && (int'(iJump_Idx) < NUM_CH)) begin
        req    = 1'b1;
        target = iJump_Idx;
      end else if (iNext || auto_req) begin
        req    = 1'b1;
        target = IDX_W'(next_idx(int'(idx), NUM_CH));
      end
    end
    change          = req && (target != idx);
    dwell_clr       = req || !iAuto_En;
    mode_next[target] = 1'b1;
    if (change && (BLANK_TICKS > 0))          state_next = BLANK;
    else if ((state == BLANK) && blank_done)  state_next = SHOW;
    show_now = (state == SHOW) && (state_next == SHOW);
  end

  mode_tick_counter #(.TERM(DWELL_TICKS)) u_dwell (
    .clk   (iClk),
    .rst_n (iRst_n),
    .clr   (dwell_clr),
    .en    (iAuto_En && !lock),
    .tick  (iTick),
    .term  (auto_req)
  );

  mode_tick_counter #(.TERM(BLANK_TERM)) u_blank (
    .clk   (iClk),
    .rst_n (iRst_n),
    .clr   (change),
    .en    (state == BLANK),
    .tick  (iTick),
    .term  (blank_done)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= SHOW;
    else         state <= state_next;
  end

  // Output register stage
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      idx        <= '0;
      mode       <= NUM_CH'(1);
      data_p1    <= '0;
      set_p1     <= '0;
      valid_p1   <= 1'b0;
      changed_p1 <= 1'b0;
    end else begin
      changed_p1 <= change;
      if (change) begin
        idx  <= target;
        mode <= mode_next;
      end
      if (show_now) begin
        data_p1  <= data_arr[idx];
        set_p1   <= SET_MASK[idx] ? set_arr[idx] : '0;
        valid_p1 <= 1'b1;
      end else begin
        data_p1  <= '0;
        set_p1   <= '0;
        valid_p1 <= 1'b0;
      end
    end
  end

  assign oMode      = mode;
  assign oMode_Idx  = idx;
  assign oMode_Set  = set_p1;
  assign oMode_Data = data_p1;
  assign oValid     = valid_p1;
  assign oChanged   = changed_p1;

endmodule
